// File: rtl/pause_continue_ctrl_if.sv
// rtl/pause_continue_ctrl_if.sv - PAUSE handshake bundle between the ISDU and pause_continue_ctrl
// Signals:
//   Pause_req  - ISDU -> ctrl, level, high while the ISDU sits in PAUSE
//   LD_LED     - ctrl -> LED register, one-cycle load strobe for IR[11:0]
//   Pause_done - ctrl -> ISDU, one-cycle pulse, pause complete
//   Paused     - ctrl -> ISDU/status, level, high while the pause is in progress
// Modports: master = ISDU side, slave = pause_continue_ctrl side.
interface pause_continue_ctrl_if;
  logic Pause_req;
  logic LD_LED;
  logic Pause_done;
  logic Paused;

  modport master (output Pause_req, input LD_LED, input Pause_done, input Paused);
  modport slave  (input Pause_req, output LD_LED, output Pause_done, output Paused);
endinterface

// File: rtl/pause_continue_ctrl.sv
// rtl/pause_continue_ctrl.sv - Continue button sync/debounce and PAUSE handshake for the SLC-3
// Ports:
//   Clk          - system clock, all state on posedge
//   Reset        - synchronous, active-high reset
//   Continue_n   - raw Continue pushbutton, active-low, asynchronous to Clk
//   isdu         - slave side of pause_continue_ctrl_if (Pause_req in; LD_LED, Pause_done, Paused out)
//   Cont_pressed - debounced button level, 1 = pressed
//   Cont_pulse   - one-cycle pulse on each debounced press edge
module pause_continue_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Continue_n,
  pause_continue_ctrl_if.slave   isdu,
  output logic                   Cont_pressed,
  output logic                   Cont_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ARM,
    WAIT_PRESS,
    WAIT_REL,
    DONE
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_pressed;
  logic [CNT_W-1:0]       db_cnt;
  logic                   db_flip;

  state_t state;
  state_t state_next;
  logic   ld_led;
  logic   pause_done;
  logic   paused;

  // Flops reset to 1 so a button held through reset reads as released
  // and has to re-debounce from scratch.
  assign sync_pressed = ~sync_q[SYNC_STAGES-1];

  // Accept the new level only on the DEBOUNCE_CYCLES-th consecutive mismatch.
  assign db_flip = (sync_pressed != Cont_pressed) && (db_cnt == DB_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q       <= '1;
      db_cnt       <= '0;
      Cont_pressed <= 1'b0;
      Cont_pulse   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], Continue_n};
      if ((sync_pressed == Cont_pressed) || db_flip) begin
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + CNT_W'(1);
      end
      if (db_flip) begin
        Cont_pressed <= ~Cont_pressed;
      end
      // Rises together with Cont_pressed, only on the press direction.
      Cont_pulse <= db_flip & ~Cont_pressed;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ld_led     = 1'b0;
    pause_done = 1'b0;
    paused     = 1'b0;
    case (state)
      IDLE: begin
        if (isdu.Pause_req) state_next = LOAD;
      end
      LOAD: begin
        ld_led = 1'b1;
        paused = 1'b1;
        // A button still held from the previous pause must be let go first.
        if (!isdu.Pause_req)  state_next = IDLE;
        else if (Cont_pressed) state_next = ARM;
        else                   state_next = WAIT_PRESS;
      end
      ARM: begin
        paused = 1'b1;
        if (!isdu.Pause_req)   state_next = IDLE;
        else if (!Cont_pressed) state_next = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        paused = 1'b1;
        if (!isdu.Pause_req)  state_next = IDLE;
        else if (Cont_pressed) state_next = WAIT_REL;
      end
      WAIT_REL: begin
        paused = 1'b1;
        if (!isdu.Pause_req)   state_next = IDLE;
        else if (!Cont_pressed) state_next = DONE;
      end
      DONE: begin
        // Always back to IDLE so a still-high Pause_req re-strobes LD_LED.
        pause_done = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign isdu.LD_LED     = ld_led;
  assign isdu.Pause_done = pause_done;
  assign isdu.Paused     = paused;

endmodule

// File: doc/pause_continue_ctrl.md
Name: pause_continue_ctrl

Overview:
- Sits directly upstream of the LED display register in the SLC-3 datapath.
- Synchronizes and debounces the raw active-low Continue pushbutton.
- Runs the PAUSE-instruction handshake with the ISDU. It issues the one-cycle LD_LED strobe that latches IR[11:0] onto the LEDs, waits for a full press-and-release of Continue, then returns Pause_done to the ISDU.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the Continue_n synchronizer chain (minimum 2).
- DEBOUNCE_CYCLES, 500000, consecutive cycles a new button level must hold before it is accepted (10 ms at 50 MHz).
- CNT_W, 20, width of the debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- Continue_n  in  1  raw Continue pushbutton, active-low, asynchronous to Clk
- Pause_req  in  1  level from ISDU, high while the ISDU sits in its PAUSE state
- LD_LED  out  1  one-cycle strobe to the LED register load input
- Pause_done  out  1  one-cycle pulse telling the ISDU the pause is complete
- Paused  out  1  level, high from the LOAD state through WAIT_REL inclusive
- Cont_pressed  out  1  debounced button level (1 = pressed)
- Cont_pulse  out  1  one-cycle pulse on each debounced press edge

Behaviour:
- Clock and reset: reset Reset, synchronous, active-high; clock Clk. All state updates on posedge Clk.
- Reset values:
  - synchronizer flops = 1 (released);
  - debounce counter = 0;
  - Cont_pressed = 0;
  - FSM = IDLE;
  - LD_LED = Pause_done = Paused = Cont_pulse = 0.
- Synchronizer: SYNC_STAGES-flop chain on Continue_n. sync_pressed = ~last stage.
- Debounce:
  - When sync_pressed == Cont_pressed, the counter clears to 0.
  - Otherwise the counter increments.
  - When a mismatching cycle finds the counter at DEBOUNCE_CYCLES-1, Cont_pressed toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES mismatching cycles produces no change.
  - Worst-case latency from a clean edge on Continue_n to a Cont_pressed change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Cont_pulse: registered, high for exactly one cycle after Cont_pressed rises 0->1. No pulse on release.
- FSM states and transitions:
  - IDLE: outputs 0. Pause_req=1 -> LOAD.
  - LOAD: LD_LED=1 for this single cycle.
    - If Cont_pressed=1 -> ARM (button already held from the previous pause; it must be released first).
    - Else -> WAIT_PRESS.
  - ARM: wait for Cont_pressed=0 -> WAIT_PRESS.
  - WAIT_PRESS: Cont_pressed=1 -> WAIT_REL.
  - WAIT_REL: Cont_pressed=0 -> DONE.
  - DONE: Pause_done=1 for one cycle -> IDLE, unconditionally.
- Paused = 1 in LOAD, ARM, WAIT_PRESS and WAIT_REL; 0 in IDLE and DONE.
- Abort: Pause_req=0 in LOAD, ARM, WAIT_PRESS or WAIT_REL -> IDLE next cycle. No Pause_done. The LED register keeps its latched value.
- Pause_req still high in DONE: FSM still returns to IDLE. Re-entry to LOAD requires Pause_req high in IDLE. Back-to-back PAUSE instructions therefore re-strobe LD_LED once per instruction.
- Exactly one LD_LED pulse and at most one Pause_done pulse per IDLE->LOAD entry. LD_LED and Pause_done are never high together.
- Reset mid-operation (any state, mid-debounce): all state returns to reset values on the next edge. A held button reads as released until it has re-debounced through the full DEBOUNCE_CYCLES.
- Outputs are Moore (state-decoded), except Cont_pulse, which is registered.

Test Plan:
- All scenarios use DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
1. Reset asserted 3 cycles with Continue_n=0 -> every output 0 during reset. After release, Cont_pressed rises 6 cycles later (2 sync + 4 stable) and Cont_pulse is high exactly 1 cycle.
2. Continue_n glitch low for 3 cycles then high -> Cont_pressed stays 0, counter returns to 0, no Cont_pulse.
3. Pause_req=1 with button released -> LD_LED high exactly 1 cycle after the request edge, Paused=1. Clean press, then release. Pause_done pulses 1 cycle once release is debounced, then Paused=0 and the FSM is in IDLE.
4. Pause_req=1 while Cont_pressed=1 (held over from the prior pause) -> FSM waits in ARM, no Pause_done. It needs release, press and release again before Pause_done pulses once.
5. Pause_req dropped while in WAIT_PRESS -> IDLE next cycle, Paused=0, Pause_done never asserted. A later Pause_req yields a fresh single LD_LED pulse.
6. Reset asserted in WAIT_REL with the button held -> next cycle IDLE, Cont_pressed=0. Then Pause_req=1 with the button still held -> LOAD then WAIT_PRESS, and a press is detected after a 4-cycle debounce.
